// File: rtl/axilite_pkg.sv
// Shared types for the AXI4-Lite RAM slave: response codes, FSM state encodings, strobe width helper.
package axilite_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_ADDR,
      WR_DATA
   } wr_state_t;

   typedef enum logic {
      RD_IDLE,
      RD_DATA
   } rd_state_t;

   function automatic int strb_width(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/axilite_ram_if.sv
// AXI4-Lite bus bundle between a master and the RAM slave; the master drives VALIDs and B/R READYs.
interface axilite_ram_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   import axilite_pkg::*;

   localparam int STRB_W = strb_width(DATA_WIDTH);

   logic [ADDR_WIDTH-1:0] AWADDR;
   logic                  AWVALID;
   logic                  AWREADY;
   logic [DATA_WIDTH-1:0] WDATA;
   logic [STRB_W-1:0]     WSTRB;
   logic                  WVALID;
   logic                  WREADY;
   logic [1:0]            BRESP;
   logic                  BVALID;
   logic                  BREADY;
   logic [ADDR_WIDTH-1:0] ARADDR;
   logic                  ARVALID;
   logic                  ARREADY;
   logic [DATA_WIDTH-1:0] RDATA;
   logic [1:0]            RRESP;
   logic                  RVALID;
   logic                  RREADY;

   modport master (
      output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport slave (
      input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

endinterface

// File: rtl/axilite_ram_core.sv
// Byte-enabled 1W/1R single-clock word array; read data registered on re, held otherwise.
// No reset on storage or read register so the array maps onto block RAM.
module axilite_ram_core #(
   parameter  int DATA_WIDTH = 32,
   parameter  int MEM_DEPTH  = 256,
   localparam int IDX_W      = $clog2(MEM_DEPTH),
   localparam int STRB_W     = DATA_WIDTH / 8
)(
   input  logic                  clk,
   input  logic                  we,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [STRB_W-1:0]     wr_strb,
   input  logic                  re,
   input  logic [IDX_W-1:0]      rd_idx,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   // Read samples the pre-write contents when both ports hit the same word.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
         end
      end
      if (re) rd_data <= mem[rd_idx];
   end

endmodule

// File: rtl/axilite_ram.sv
// AXI4-Lite RAM slave: independent AW/W capture, 1-cycle read latency, B/R held until READY.
// Define AXILITE_RAM_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axilite_ram
   import axilite_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    MEM_DEPTH  = 256,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
)(
   input logic          ACLK,
   input logic          ARESET,
   axilite_ram_if.slave bus
);

   localparam int STRB_W = strb_width(DATA_WIDTH);
   localparam int SHIFT  = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(MEM_DEPTH);

`ifdef AXILITE_RAM_SLVERR_EN
   localparam resp_t ERR_RESP = SLVERR;
`else
   localparam resp_t ERR_RESP = OKAY;
`endif

   typedef logic [ADDR_WIDTH-1:0] addr_t;

   function automatic logic in_range(input addr_t a);
      addr_t word;
      word = (a - BASE_ADDR) >> SHIFT;
      return (a >= BASE_ADDR) && (word < addr_t'(MEM_DEPTH));
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input addr_t a);
      return IDX_W'((a - BASE_ADDR) >> SHIFT);
   endfunction

   wr_state_t wr_state, wr_state_nxt;
   rd_state_t rd_state, rd_state_nxt;

   addr_t                 aw_addr_q;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic [STRB_W-1:0]     w_strb_q;
   logic                  b_vld;
   resp_t                 b_resp;
   resp_t                 r_resp;
   logic                  r_ok;

   logic                  aw_rdy, w_rdy, ar_rdy, b_free;
   logic                  aw_hs, w_hs, ar_hs;
   logic                  have_addr, have_data, commit;
   addr_t                 wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [STRB_W-1:0]     wr_strb;
   logic                  wr_ok, ar_ok;
   logic [DATA_WIDTH-1:0] core_rd;

   // A commit needs a free B slot, so an unaccepted response is never overwritten.
   assign b_free = !b_vld || bus.BREADY;
   assign aw_rdy = !ARESET && b_free && (wr_state != WR_ADDR);
   assign w_rdy  = !ARESET && b_free && (wr_state != WR_DATA);
   assign ar_rdy = !ARESET && ((rd_state != RD_DATA) || bus.RREADY);

   assign aw_hs = bus.AWVALID && aw_rdy;
   assign w_hs  = bus.WVALID && w_rdy;
   assign ar_hs = bus.ARVALID && ar_rdy;

   assign wr_ok = in_range(wr_addr);
   assign ar_ok = in_range(bus.ARADDR);

   always_comb begin
      wr_state_nxt = wr_state;
      have_addr    = (wr_state == WR_ADDR) || aw_hs;
      have_data    = (wr_state == WR_DATA) || w_hs;
      commit       = have_addr && have_data;
      wr_addr      = (wr_state == WR_ADDR) ? aw_addr_q : bus.AWADDR;
      wr_data      = (wr_state == WR_DATA) ? w_data_q : bus.WDATA;
      wr_strb      = (wr_state == WR_DATA) ? w_strb_q : bus.WSTRB;
      if (commit)     wr_state_nxt = WR_IDLE;
      else if (aw_hs) wr_state_nxt = WR_ADDR;
      else if (w_hs)  wr_state_nxt = WR_DATA;
   end

   always_comb begin
      rd_state_nxt = rd_state;
      if (ar_hs)            rd_state_nxt = RD_DATA;
      else if (bus.RREADY)  rd_state_nxt = RD_IDLE;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wr_state <= WR_IDLE;
         rd_state <= RD_IDLE;
      end else begin
         wr_state <= wr_state_nxt;
         rd_state <= rd_state_nxt;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         b_vld     <= 1'b0;
         b_resp    <= OKAY;
         r_resp    <= OKAY;
         r_ok      <= 1'b0;
      end else begin
         if (aw_hs) aw_addr_q <= bus.AWADDR;
         if (w_hs) begin
            w_data_q <= bus.WDATA;
            w_strb_q <= bus.WSTRB;
         end
         // New commit on the B handshake edge keeps BVALID up with the fresh response.
         if (commit) begin
            b_vld  <= 1'b1;
            b_resp <= wr_ok ? OKAY : ERR_RESP;
         end else if (bus.BREADY) begin
            b_vld  <= 1'b0;
         end
         if (ar_hs) begin
            r_resp <= ar_ok ? OKAY : ERR_RESP;
            r_ok   <= ar_ok;
         end
      end
   end

   axilite_ram_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH)
   ) u_core (
      .clk     (ACLK),
      .we      (commit && wr_ok),
      .wr_idx  (word_idx(wr_addr)),
      .wr_data (wr_data),
      .wr_strb (wr_strb),
      .re      (ar_hs && ar_ok),
      .rd_idx  (word_idx(bus.ARADDR)),
      .rd_data (core_rd)
   );

   assign bus.AWREADY = aw_rdy;
   assign bus.WREADY  = w_rdy;
   assign bus.ARREADY = ar_rdy;
   assign bus.BVALID  = b_vld;
   assign bus.BRESP   = b_resp;
   assign bus.RVALID  = (rd_state == RD_DATA);
   assign bus.RRESP   = r_resp;
   assign bus.RDATA   = ((rd_state == RD_DATA) && r_ok) ? core_rd : '0;

endmodule

// File: tb/tb_axilite_ram.sv
// Scoreboarded bench for axilite_ram: directed corner cases plus random traffic against an array model.
module tb_axilite_ram;
   import axilite_pkg::*;

   localparam int          DW    = 32;
   localparam int          AW    = 32;
   localparam int          DEPTH = 256;
   localparam logic [31:0] BASE  = 32'h0;
`ifdef AXILITE_RAM_SLVERR_EN
   localparam logic [1:0]  ERR   = 2'b10;
`else
   localparam logic [1:0]  ERR   = 2'b00;
`endif

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
   } rexp_t;

   logic ACLK = 1'b0;
   logic ARESET = 1'b1;
   always #5 ACLK = ~ACLK;

   axilite_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bif ();

   axilite_ram #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .MEM_DEPTH  (DEPTH),
      .BASE_ADDR  (BASE)
   ) dut (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .bus    (bif.slave)
   );

   logic [31:0] model [DEPTH];
   logic [1:0]  exp_b [$];
   rexp_t       exp_r [$];
   rexp_t       mon_e;
   int          n_checks = 0;
   int          n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic bit hit(input logic [31:0] a);
      longint off;
      off = longint'(a) - longint'(BASE);
      return (off >= 0) && (off / 4 < DEPTH);
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((longint'(a) - longint'(BASE)) / 4);
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      if (hit(a)) begin
         for (int b = 0; b < 4; b++) if (s[b]) model[widx(a)][b*8 +: 8] = d[b*8 +: 8];
      end
   endtask

   task automatic push_read(input logic [31:0] a);
      rexp_t e;
      e.data = hit(a) ? model[widx(a)] : 32'h0;
      e.resp = hit(a) ? 2'b00 : ERR;
      exp_r.push_back(e);
   endtask

   // Scoreboard monitor: consumes an expectation for every accepted B or R beat.
   always @(negedge ACLK) begin
      if (!ARESET) begin
         if (bif.BVALID && bif.BREADY) begin
            if (exp_b.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_b: BVALID accepted with bresp %h and no write outstanding", bif.BRESP);
            end else check("bresp", bif.BRESP, exp_b.pop_front());
         end
         if (bif.RVALID && bif.RREADY) begin
            if (exp_r.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_r: RVALID accepted with rdata %h and no read outstanding", bif.RDATA);
            end else begin
               mon_e = exp_r.pop_front();
               check("rdata", bif.RDATA, mon_e.data);
               check("rresp", bif.RRESP, mon_e.resp);
            end
         end
         if (!bif.RVALID) check("rdata_idle_zero", bif.RDATA, 0);
      end
   end

   // which: 0 = AW, 1 = W, 2 = AR. Returns just after the handshake edge.
   task automatic wait_hs(input int which, input string name);
      bit rdy;
      for (int i = 0; i < 64; i++) begin
         @(negedge ACLK);
         case (which)
            0:       rdy = bif.AWREADY;
            1:       rdy = bif.WREADY;
            default: rdy = bif.ARREADY;
         endcase
         if (rdy) begin
            @(posedge ACLK);
            #1;
            return;
         end
      end
      n_checks++;
      $display("FAIL %s_timeout: ready stayed 0 for 64 cycles, required 1", name);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int gap_aw, input int gap_w);
      exp_b.push_back(hit(a) ? 2'b00 : ERR);
      model_write(a, d, s);
      fork
         begin
            repeat (gap_aw) @(posedge ACLK);
            if (gap_aw > 0) #1;
            bif.AWADDR  = a;
            bif.AWVALID = 1'b1;
            wait_hs(0, "aw");
            bif.AWVALID = 1'b0;
         end
         begin
            repeat (gap_w) @(posedge ACLK);
            if (gap_w > 0) #1;
            bif.WDATA  = d;
            bif.WSTRB  = s;
            bif.WVALID = 1'b1;
            wait_hs(1, "w");
            bif.WVALID = 1'b0;
         end
      join
      check("bvalid_after_commit", bif.BVALID, 1'b1);
      repeat (2) @(posedge ACLK);
      #1;
   endtask

   task automatic do_read(input logic [31:0] a);
      push_read(a);
      bif.ARADDR  = a;
      bif.ARVALID = 1'b1;
      wait_hs(2, "ar");
      bif.ARVALID = 1'b0;
   endtask

   task automatic check_all_low(input string name);
      check({name, "_awready"}, bif.AWREADY, 0);
      check({name, "_wready"},  bif.WREADY,  0);
      check({name, "_arready"}, bif.ARREADY, 0);
      check({name, "_bvalid"},  bif.BVALID,  0);
      check({name, "_rvalid"},  bif.RVALID,  0);
      check({name, "_rdata"},   bif.RDATA,   0);
   endtask

   task automatic check_ready_high(input string name);
      check({name, "_awready"}, bif.AWREADY, 1);
      check({name, "_wready"},  bif.WREADY,  1);
      check({name, "_arready"}, bif.ARREADY, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] a, d;
      bif.AWADDR = '0; bif.AWVALID = 0; bif.WDATA = '0; bif.WSTRB = '0; bif.WVALID = 0;
      bif.BREADY = 1;  bif.ARADDR = '0; bif.ARVALID = 0; bif.RREADY = 1;

      // Reset state, then READYs high on the first cycle out of reset.
      repeat (2) @(posedge ACLK);
      #1;
      check_all_low("reset");
      check("reset_bresp", bif.BRESP, 0);
      check("reset_rresp", bif.RRESP, 0);
      ARESET = 1'b0;
      #1;
      check_ready_high("post_reset");

      for (int w = 0; w < 16; w++)
         do_write(BASE + 32'(w * 4), $urandom, 4'hF, $urandom_range(0, 2), $urandom_range(0, 2));
      do_write(BASE + 32'((DEPTH - 1) * 4), $urandom, 4'hF, 0, 0);

      // AW first, W three cycles later.
      do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 3);
      do_read(32'h10);

      // W first, single-byte strobe over existing data.
      do_write(32'h20, 32'h11223344, 4'hF, 0, 0);
      do_write(32'h20, 32'h0000AB00, 4'h2, 2, 0);
      do_read(32'h20);

      // B backpressure holds BVALID/BRESP and blocks new AW/W.
      bif.BREADY = 1'b0;
      do_write(32'h2C, 32'hCAFE0001, 4'hF, 1, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge ACLK);
         check("bhold_bvalid", bif.BVALID, 1);
         check("bhold_bresp", bif.BRESP, 0);
         check("bhold_awready", bif.AWREADY, 0);
         check("bhold_wready", bif.WREADY, 0);
      end
      @(posedge ACLK); #1;
      bif.BREADY = 1'b1;
      @(posedge ACLK); #1;

      // Back-to-back reads, one per cycle.
      for (int i = 0; i < 3; i++) begin
         bif.ARADDR  = 32'(i * 4);
         bif.ARVALID = 1'b1;
         push_read(32'(i * 4));
         @(posedge ACLK); #1;
         check("b2b_rvalid", bif.RVALID, 1);
      end
      bif.ARVALID = 1'b0;
      @(posedge ACLK); #1;
      check("b2b_rvalid_drop", bif.RVALID, 0);

      // R backpressure holds RDATA.
      bif.RREADY = 1'b0;
      do_read(32'h24);
      for (int i = 0; i < 4; i++) begin
         @(negedge ACLK);
         check("rhold_rvalid", bif.RVALID, 1);
         check("rhold_rdata", bif.RDATA, model[9]);
         check("rhold_arready", bif.ARREADY, 0);
      end
      @(posedge ACLK); #1;
      bif.RREADY = 1'b1;
      @(posedge ACLK); #1;

      // Read and write commit to the same word on the same edge: old data returned.
      exp_b.push_back(2'b00);
      bif.AWADDR = 32'h30; bif.AWVALID = 1'b1;
      wait_hs(0, "aw_same_edge");
      bif.AWVALID = 1'b0;
      push_read(32'h30);
      model_write(32'h30, 32'h5A5A0F0F, 4'hF);
      bif.WDATA = 32'h5A5A0F0F; bif.WSTRB = 4'hF; bif.WVALID = 1'b1;
      bif.ARADDR = 32'h30; bif.ARVALID = 1'b1;
      @(negedge ACLK);
      check("same_edge_wready", bif.WREADY, 1);
      check("same_edge_arready", bif.ARREADY, 1);
      @(posedge ACLK); #1;
      bif.WVALID = 1'b0; bif.ARVALID = 1'b0;
      repeat (2) @(posedge ACLK); #1;
      do_read(32'h30);

      // Out-of-range accesses leave memory alone and read as zero.
      do_write(BASE + 32'(DEPTH * 4), 32'hBAD0BAD0, 4'hF, 0, 0);
      do_write(32'hFFFF_FFF0, 32'hBAD1BAD1, 4'hF, 1, 0);
      do_read(BASE + 32'(DEPTH * 4));
      do_read(32'h0);
      do_read(BASE + 32'((DEPTH - 1) * 4));

      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 7) == 0)
            a = ($urandom_range(0, 1) == 0) ? 32'(DEPTH * 4) + 32'($urandom_range(0, 255)) : 32'hFFFF_FFF0;
         else
            a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
         d = $urandom;
         if ($urandom_range(0, 2) != 0)
            do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2));
         else
            do_read(a);
      end

      // Reset with an AW held and an R pending.
      bif.AWADDR = 32'h50; bif.AWVALID = 1'b1;
      wait_hs(0, "aw_pre_reset");
      bif.AWVALID = 1'b0;
      bif.RREADY = 1'b0;
      do_read(32'h14);
      check("pre_reset_rvalid", bif.RVALID, 1);
      ARESET = 1'b1;
      @(posedge ACLK); #1;
      check_all_low("midreset");
      exp_r.delete();
      bif.RREADY = 1'b1;
      ARESET = 1'b0;
      #1;
      check_ready_high("after_pulse");
      repeat (4) @(posedge ACLK); #1;
      check("after_pulse_bvalid", bif.BVALID, 0);
      check("after_pulse_rvalid", bif.RVALID, 0);
      do_read(32'h10);
      do_write(32'h18, 32'h0BADF00D, 4'hF, 0, 1);
      do_read(32'h18);

      repeat (3) @(posedge ACLK); #1;
      check("b_queue_drained", exp_b.size(), 0);
      check("r_queue_drained", exp_r.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/axilite_ram.md
AXILITE_RAM -- requirements
Module: axilite_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data bus width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, meaning number of DATA_WIDTH words; any value >= 2.
REQ-004 SHALL have parameter BASE_ADDR, default 0, meaning byte address of word 0; aligned to DATA_WIDTH/8.
REQ-005 SHALL use one clock and a synchronous, active-high reset: ACLK in 1 (clock); ARESET in 1 (sync reset, active high).
REQ-006 SHALL have these write ports: AWADDR in ADDR_WIDTH, AWVALID in 1, AWREADY out 1, WDATA in DATA_WIDTH, WSTRB in DATA_WIDTH/8, WVALID in 1, WREADY out 1, BRESP out 2, BVALID out 1, BREADY in 1.
REQ-007 SHALL have these read ports: ARADDR in ADDR_WIDTH, ARVALID in 1, ARREADY out 1, RDATA out DATA_WIDTH, RRESP out 2, RVALID out 1, RREADY in 1.

Function
REQ-008 SHALL decode the word index as (ADDR-BASE_ADDR)>>log2(DATA_WIDTH/8), ignoring the low byte-offset bits.
REQ-009 SHALL treat an access as in range only when ADDR>=BASE_ADDR and the index is <MEM_DEPTH.
REQ-010 SHALL implement write FSM states WR_IDLE, WR_ADDR (AW held, waiting W) and WR_DATA (W held, waiting AW), with AW and W accepted independently in either order or in the same cycle.
REQ-011 SHALL drive AWREADY high only when no AW is held and the B slot is free (BVALID low, or BREADY high this cycle); WREADY follows the same rule for W.
REQ-012 SHALL commit a write on the edge at which both address and data are available (held or handshaking), writing only bytes whose WSTRB bit is set, and SHALL then return to WR_IDLE.
REQ-013 SHALL assert BVALID on the cycle after commit and hold it and BRESP stable until BREADY; a commit on the same edge as B handshake SHALL keep BVALID high with the new BRESP.
REQ-014 SHALL implement read FSM states RD_IDLE and RD_DATA, with ARREADY = !RVALID || RREADY, giving one read per cycle under no backpressure.
REQ-015 SHALL register RDATA/RRESP at the AR handshake edge, giving 1-cycle latency; RVALID, RDATA and RRESP SHALL be held stable until RREADY.
REQ-016 SHALL make a read handshaking on the same edge as a write commit to the same word return the pre-write (old) data.
REQ-017 SHALL leave memory unmodified by out-of-range writes and return RDATA=0 for out-of-range reads.
REQ-018 SHALL drive RDATA=0 whenever RVALID is low.

Reset
REQ-019 SHALL, on ARESET high at an ACLK edge, force both FSMs to idle, discard held AW/W and pending B/R, and drive AWREADY/WREADY/ARREADY/BVALID/RVALID=0, BRESP/RRESP=0, RDATA=0.
REQ-020 SHALL leave memory contents unchanged by reset, so RAM inference is kept.
REQ-021 SHALL drive the READY outputs high on the first cycle after ARESET deasserts.

Configuration
REQ-022 SHALL, with AXILITE_RAM_SLVERR_EN defined, return BRESP/RRESP=SLVERR (2'b10) for out-of-range accesses.
REQ-023 SHALL, without AXILITE_RAM_SLVERR_EN, return OKAY (2'b00) for all accesses; REQ-017 data behaviour is unchanged.

Structure
REQ-024 SHALL place in package axilite_pkg: the resp_t enum (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11), the wr_state_t and rd_state_t enums, and the function deriving the strobe width.
REQ-025 SHALL put storage in sub-module axilite_ram_core, a single-clock, byte-enabled, 1-write/1-read-port array of MEM_DEPTH x DATA_WIDTH with registered read.
REQ-026 SHALL hold the handshake FSMs, decode and response logic in axilite_ram; the target size is 150-300 RTL lines total.

Verification
REQ-027 AW 0x10 then W 0xDEADBEEF strobe 0xF three cycles later -> single commit, BVALID 1 cycle after W, then a read of 0x10 returns 0xDEADBEEF, RRESP=OKAY.
REQ-028 W before AW, then write 0x0000AB00 to 0x20 with strobe 0x2 over prior 0x11223344 -> read returns 0x1122AB44.
REQ-029 Hold BREADY=0 for 5 cycles after a write -> BVALID/BRESP stable, AWREADY=WREADY=0 until B handshake.
REQ-030 Back-to-back ARs to 0x0, 0x4, 0x8 with RREADY=1 -> RVALID high 3 consecutive cycles, data in order; RREADY=0 -> RDATA held.
REQ-031 Read/write of MEM_DEPTH*4+BASE_ADDR -> SLVERR with macro, OKAY without; memory untouched; RDATA=0.
REQ-032 ARESET pulsed while AW held and RVALID high -> all VALID/READY=0 next cycle, no B/R issued afterwards, previously written word intact.
